// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter
//
// Shares one single-port memory bus between instruction fetch (inst_*) and
// data access (data_*). The winning request is latched into the bus
// registers and held until the bus acknowledges. The read word is then
// handed back to the requester that owns the transaction, as a one-cycle
// ok pulse.
//
// Data requests normally win. A run counter limits how many data grants in
// a row may be made while a fetch is waiting. A watchdog aborts a bus
// transaction that is never acknowledged and sets a sticky error flag.
//
// Parameters
//   MAX_DATA_RUN : consecutive data grants allowed while inst_req waits
//   TIMEOUT      : non-IDLE cycles allowed without bus_ack (>= 2)
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   inst_req/addr/cancel       fetch request, address, pipeline flush
//   inst_ok/rdata              fetch done pulse and fetched word
//   data_req/we/addr/wdata/wstrb  data request and store fields
//   data_ok/rdata              data done pulse and load word
//   stall                      pipeline hold while any access is outstanding
//   bus_req/we/addr/wdata/wstrb   memory bus request side
//   bus_ack/rdata              memory bus completion and read data
//   bus_err                    sticky watchdog timeout flag
module mem_bus_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_INST,
    ST_DRAIN
  } state_t;

  state_t            state_reg;
  logic [RUN_W-1:0]  run_reg;
  logic [WD_W-1:0]   wd_reg;

  logic data_elig;
  logic inst_elig;
  logic run_full;
  logic grant_data;
  logic grant_inst;
  logic wd_expired;

  // A requester whose ok pulse is high this cycle has just been served; its
  // request line may still be high and must not win a second grant.
  assign data_elig  = data_req & ~data_ok;
  assign inst_elig  = inst_req & ~inst_cancel & ~inst_ok;
  assign run_full   = (run_reg >= RUN_W'(MAX_DATA_RUN));
  assign grant_data = data_elig & (~run_full | ~inst_elig);
  assign grant_inst = ~grant_data & inst_elig;

  // wd_reg counts completed non-IDLE cycles. It holds TIMEOUT-1 during the
  // TIMEOUT-th cycle, so bus_req is high for exactly TIMEOUT cycles before
  // an abort.
  assign wd_expired = (wd_reg == WD_W'(TIMEOUT - 1));

  assign bus_req = (state_reg != ST_IDLE);

  assign stall = (data_req & ~data_ok) | (inst_req & ~inst_cancel & ~inst_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      run_reg    <= '0;
      wd_reg     <= '0;
      inst_ok    <= 1'b0;
      inst_rdata <= '0;
      data_ok    <= 1'b0;
      data_rdata <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      bus_err    <= 1'b0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;

      // Outside IDLE the run counter only needs clearing when fetch gives up.
      if (!inst_req) begin
        run_reg <= '0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (grant_data) begin
            state_reg <= ST_DATA;
            wd_reg    <= '0;
            bus_we    <= data_we;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            bus_wstrb <= data_we ? data_wstrb : 4'b0000;
            // Count data wins against a waiting fetch; saturate so that a
            // cancelled-but-still-requesting fetch cannot wrap the counter.
            if (inst_req && !run_full) begin
              run_reg <= run_reg + RUN_W'(1);
            end
          end else if (grant_inst) begin
            state_reg <= ST_INST;
            wd_reg    <= '0;
            run_reg   <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
          end
        end

        ST_DATA: begin
          if (bus_ack) begin
            state_reg  <= ST_IDLE;
            data_ok    <= 1'b1;
            data_rdata <= bus_rdata;
          end else if (wd_expired) begin
            state_reg  <= ST_IDLE;
            bus_err    <= 1'b1;
            data_ok    <= 1'b1;
            data_rdata <= '0;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end

        ST_INST: begin
          if (bus_ack) begin
            state_reg <= ST_IDLE;
            // A flush coinciding with the ack throws the word away.
            if (!inst_cancel) begin
              inst_ok    <= 1'b1;
              inst_rdata <= bus_rdata;
            end
          end else if (wd_expired) begin
            state_reg <= ST_IDLE;
            bus_err   <= 1'b1;
            if (!inst_cancel) begin
              inst_ok    <= 1'b1;
              inst_rdata <= '0;
            end
          end else if (inst_cancel) begin
            // The bus cycle is already under way and cannot be withdrawn,
            // so wait out its ack without returning anything. The watchdog
            // keeps counting because this is the same bus transaction.
            state_reg <= ST_DRAIN;
            wd_reg    <= wd_reg + WD_W'(1);
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end

        ST_DRAIN: begin
          if (bus_ack) begin
            state_reg <= ST_IDLE;
          end else if (wd_expired) begin
            state_reg <= ST_IDLE;
            bus_err   <= 1'b1;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_bus_arbiter. Inputs are driven and outputs are
// sampled at the falling edge. "Cycle n" of a scenario is the clock period
// that contains its n-th falling edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_cancel = 1'b0;
  logic        inst_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_ok(inst_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_ok(data_ok), .data_rdata(data_rdata),
    .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) cyc();
    tests_run++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got req=%0b we=%0b addr=%h wdata=%h wstrb=%h err=%0b, expected all 0",
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_err);
    end
    tests_run++;
    if ({inst_ok, inst_rdata, data_ok, data_rdata, stall} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ok: got inst_ok=%0b inst_rdata=%h data_ok=%0b data_rdata=%h stall=%0b, expected all 0",
               inst_ok, inst_rdata, data_ok, data_rdata, stall);
    end
    reset = 1'b1;
    cyc();
    $display("[TB] reset released");
  endtask

  task automatic test_load();
    cyc();  // cycle 0
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
    data_wdata = 32'hFFFF_FFFF; data_wstrb = 4'hF;
    #1;
    tests_run++;
    if (stall !== 1'b1 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_c0: got stall=%0b bus_req=%0b, expected stall=1 bus_req=0", stall, bus_req);
    end
    cyc();  // cycle 1
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0 || bus_wstrb !== 4'b0000 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_bus: got req=%0b addr=%h we=%0b wstrb=%b stall=%0b, expected 1 00000100 0 0000 1",
               bus_req, bus_addr, bus_we, bus_wstrb, stall);
    end
    cyc();  // cycle 2
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #1;
    tests_run++;
    if (stall !== 1'b1 || data_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_c2: got stall=%0b data_ok=%0b, expected stall=1 data_ok=0", stall, data_ok);
    end
    cyc();  // cycle 3
    bus_ack = 1'b0; bus_rdata = '0;
    tests_run++;
    if (data_ok !== 1'b1 || data_rdata !== 32'hCAFE_F00D || stall !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_ok: got ok=%0b rdata=%h stall=%0b bus_req=%0b, expected 1 cafef00d 0 0",
               data_ok, data_rdata, stall, bus_req);
    end
    data_req = 1'b0;
    cyc();  // cycle 4
    tests_run++;
    if (data_ok !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_pulse: got data_ok=%0b bus_req=%0b, expected 0 0", data_ok, bus_req);
    end
    $display("[TB] load addr=00000100 rdata=%h", data_rdata);
  endtask

  task automatic test_simultaneous();
    cyc();  // cycle 0
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40;
    data_wdata = 32'h1122_3344; data_wstrb = 4'b0011;
    cyc();  // cycle 1: data store owns the bus
    tests_run++;
    if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h40 || bus_wdata !== 32'h1122_3344 || bus_wstrb !== 4'b0011) begin
      tests_failed++;
      $display("FAIL sim_store: got req=%0b we=%0b addr=%h wdata=%h wstrb=%b, expected 1 1 00000040 11223344 0011",
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb);
    end
    bus_ack = 1'b1; bus_rdata = 32'h0;
    cyc();  // cycle 2
    bus_ack = 1'b0;
    tests_run++;
    if (data_ok !== 1'b1 || inst_ok !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_data_ok: got data_ok=%0b inst_ok=%0b bus_req=%0b, expected 1 0 0", data_ok, inst_ok, bus_req);
    end
    data_req = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL sim_stall: got stall=%0b, expected 1 while fetch waits", stall);
    end
    cyc();  // cycle 3: fetch granted right after data_ok
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h1000 || bus_we !== 1'b0 || bus_wstrb !== 4'b0000) begin
      tests_failed++;
      $display("FAIL sim_inst_bus: got req=%0b addr=%h we=%0b wstrb=%b, expected 1 00001000 0 0000",
               bus_req, bus_addr, bus_we, bus_wstrb);
    end
    bus_ack = 1'b1; bus_rdata = 32'h8BAD_F00D;
    cyc();  // cycle 4
    bus_ack = 1'b0; bus_rdata = '0;
    tests_run++;
    if (inst_ok !== 1'b1 || inst_rdata !== 32'h8BAD_F00D) begin
      tests_failed++;
      $display("FAIL sim_inst_ok: got ok=%0b rdata=%h, expected 1 8badf00d", inst_ok, inst_rdata);
    end
    inst_req = 1'b0;
    $display("[TB] store 00000040 then fetch 00001000 rdata=%h", inst_rdata);
  endtask

  // Data keeps requesting while fetch is held. The fetch is flushed in
  // every data_ok cycle, so the only thing that can hand fetch the bus is
  // the run limit: 4 data grants must happen first.
  task automatic test_starvation();
    int data_grants = 0;
    bit inst_seen = 1'b0;
    bit inst_ok_seen = 1'b0;
    logic [31:0] ok_word = '0;
    cyc();
    inst_req = 1'b1; inst_addr = 32'h2000;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
    for (int i = 0; i < 40 && !inst_ok_seen; i++) begin
      cyc();
      inst_cancel = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      if (inst_ok) begin
        inst_ok_seen = 1'b1;
        ok_word = inst_rdata;
      end else begin
        if (data_ok) inst_cancel = 1'b1;
        if (bus_req) begin
          bus_ack = 1'b1;
          if (bus_addr == 32'h300 && !inst_seen) data_grants++;
          if (bus_addr == 32'h2000) begin
            inst_seen = 1'b1;
            bus_rdata = 32'h1357_9BDF;
          end
        end
      end
    end
    inst_req = 1'b0; data_req = 1'b0; inst_cancel = 1'b0; bus_ack = 1'b0;
    tests_run++;
    if (data_grants != 4) begin
      tests_failed++;
      $display("FAIL starve_grants: got %0d data grants before fetch, expected 4", data_grants);
    end
    tests_run++;
    if (!inst_ok_seen || ok_word !== 32'h1357_9BDF) begin
      tests_failed++;
      $display("FAIL starve_inst: got inst_ok_seen=%0b word=%h, expected 1 13579bdf", inst_ok_seen, ok_word);
    end
    cyc();
    $display("[TB] starvation data_grants=%0d then fetch word=%h", data_grants, ok_word);
  endtask

  task automatic test_flush();
    // Cancel two cycles before the ack.
    cyc();  // cycle 0
    inst_req = 1'b1; inst_addr = 32'h2000;
    cyc();  // cycle 1
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h2000) begin
      tests_failed++;
      $display("FAIL flush_grant: got req=%0b addr=%h, expected 1 00002000", bus_req, bus_addr);
    end
    cyc();  // cycle 2
    inst_cancel = 1'b1;
    cyc();  // cycle 3: draining, new fetch presented
    inst_cancel = 1'b0; inst_addr = 32'h3000;
    #1;
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h2000 || inst_ok !== 1'b0 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_drain: got req=%0b addr=%h inst_ok=%0b stall=%0b, expected 1 00002000 0 1",
               bus_req, bus_addr, inst_ok, stall);
    end
    cyc();  // cycle 4
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_0001;
    cyc();  // cycle 5
    bus_ack = 1'b0; bus_rdata = '0;
    tests_run++;
    if (inst_ok !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_ok: got inst_ok=%0b bus_req=%0b, expected 0 0", inst_ok, bus_req);
    end
    cyc();  // cycle 6
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h3000) begin
      tests_failed++;
      $display("FAIL flush_new: got req=%0b addr=%h, expected 1 00003000", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h3333_0000;
    cyc();  // cycle 7
    bus_ack = 1'b0; bus_rdata = '0;
    tests_run++;
    if (inst_ok !== 1'b1 || inst_rdata !== 32'h3333_0000) begin
      tests_failed++;
      $display("FAIL flush_new_ok: got ok=%0b rdata=%h, expected 1 33330000", inst_ok, inst_rdata);
    end
    inst_req = 1'b0;
    $display("[TB] flush early: dropped 00002000, fetched 00003000 rdata=%h", inst_rdata);

    // Cancel in the same cycle as the ack.
    cyc();
    cyc();  // cycle 0
    inst_req = 1'b1; inst_addr = 32'h4000;
    cyc();  // cycle 1
    bus_ack = 1'b1; bus_rdata = 32'h4444_0000;
    inst_cancel = 1'b1; inst_req = 1'b0;
    cyc();  // cycle 2
    bus_ack = 1'b0; bus_rdata = '0; inst_cancel = 1'b0;
    tests_run++;
    if (inst_ok !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ack: got inst_ok=%0b bus_req=%0b, expected 0 0", inst_ok, bus_req);
    end
    cyc();  // cycle 3
    tests_run++;
    if (inst_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ack_late: got inst_ok=%0b, expected 0", inst_ok);
    end
    $display("[TB] flush with ack: fetch 00004000 discarded");
  endtask

  task automatic test_watchdog();
    int req_cycles = 0;
    cyc();  // cycle 0
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h500;
    bus_rdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (bus_req === 1'b1) req_cycles++;
    end
    tests_run++;
    if (req_cycles != 8 || bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_wait: got %0d bus_req cycles err=%0b, expected 8 0", req_cycles, bus_err);
    end
    cyc();  // cycle 9
    tests_run++;
    if (bus_req !== 1'b0 || bus_err !== 1'b1 || data_ok !== 1'b1 || data_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL wd_abort: got req=%0b err=%0b ok=%0b rdata=%h, expected 0 1 1 00000000",
               bus_req, bus_err, data_ok, data_rdata);
    end
    data_req = 1'b0; bus_rdata = '0;
    cyc();  // cycle 10
    data_req = 1'b1; data_addr = 32'h600;
    cyc();  // cycle 11
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h600) begin
      tests_failed++;
      $display("FAIL wd_after_bus: got req=%0b addr=%h, expected 1 00000600", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    cyc();  // cycle 12
    bus_ack = 1'b0; bus_rdata = '0;
    tests_run++;
    if (data_ok !== 1'b1 || data_rdata !== 32'h1234_5678 || bus_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_after_ok: got ok=%0b rdata=%h err=%0b, expected 1 12345678 1", data_ok, data_rdata, bus_err);
    end
    data_req = 1'b0;
    $display("[TB] watchdog abort after %0d cycles, later load rdata=%h err=%0b", req_cycles, data_rdata, bus_err);
  endtask

  task automatic test_async_reset();
    cyc();  // cycle 0
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h700;
    cyc();  // cycle 1
    tests_run++;
    if (bus_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_pre: got bus_req=%0b, expected 1", bus_req);
    end
    #2;
    reset = 1'b0; data_req = 1'b0;
    #1;  // still well before the next rising edge
    tests_run++;
    if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_err, data_ok, inst_ok} !== '0) begin
      tests_failed++;
      $display("FAIL arst_now: got req=%0b we=%0b addr=%h wstrb=%b err=%0b data_ok=%0b inst_ok=%0b, expected all 0",
               bus_req, bus_we, bus_addr, bus_wstrb, bus_err, data_ok, inst_ok);
    end
    cyc();  // cycle 2
    bus_ack = 1'b1; bus_rdata = 32'h0000_BEEF;
    cyc();  // cycle 3
    bus_ack = 1'b0; bus_rdata = '0;
    reset = 1'b1;
    cyc();  // cycle 4: a stray ack in IDLE
    tests_run++;
    if (data_ok !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_release: got data_ok=%0b bus_req=%0b, expected 0 0", data_ok, bus_req);
    end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    cyc();  // cycle 5
    bus_ack = 1'b0; bus_rdata = '0;
    tests_run++;
    if (data_ok !== 1'b0 || inst_ok !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ack: got data_ok=%0b inst_ok=%0b bus_req=%0b, expected 0 0 0", data_ok, inst_ok, bus_req);
    end
    data_req = 1'b1; data_addr = 32'h800;
    cyc();  // cycle 6
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h800) begin
      tests_failed++;
      $display("FAIL arst_fresh_bus: got req=%0b addr=%h, expected 1 00000800", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
    cyc();  // cycle 7
    bus_ack = 1'b0; bus_rdata = '0;
    tests_run++;
    if (data_ok !== 1'b1 || data_rdata !== 32'hA5A5_A5A5) begin
      tests_failed++;
      $display("FAIL arst_fresh_ok: got ok=%0b rdata=%h, expected 1 a5a5a5a5", data_ok, data_rdata);
    end
    data_req = 1'b0;
    $display("[TB] async reset mid-load, fresh load rdata=%h", data_rdata);
  endtask

  initial begin
    test_reset();
    test_load();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_watchdog();
    test_async_reset();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (IF) and data access (MEM).
- Registers the granted request and drives the bus until ack, then returns the read data to the owning requester.
- Produces a stall for the pipeline registers (fetch and the M/W stage register) while any access is outstanding.
- Data has priority; an anti-starvation counter guarantees fetch progress, and a watchdog prevents hangs.

Parameters:
- MAX_DATA_RUN, 4, max consecutive data grants while inst_req waits before inst is forced.
- TIMEOUT, 256, cycles a bus transaction may stay un-acked before abort; must be ≥2.

Ports:
- clk, input, 1, clock (rising edge).
- reset, input, 1, asynchronous, active-low reset.
- inst_req, input, 1, fetch request; held until inst_ok or cancel.
- inst_addr, input, 32, fetch address.
- inst_cancel, input, 1, pipeline flush: abandon current or pending fetch.
- inst_ok, output, 1, one-cycle pulse: inst_rdata valid.
- inst_rdata, output, 32, fetched word.
- data_req, input, 1, data request; held until data_ok.
- data_we, input, 1, 1=store, 0=load.
- data_addr, input, 32, data address.
- data_wdata, input, 32, store data.
- data_wstrb, input, 4, byte enables for stores.
- data_ok, output, 1, one-cycle pulse: access done, data_rdata valid for loads.
- data_rdata, output, 32, load data.
- stall, output, 1, pipeline hold request.
- bus_req, output, 1, bus transaction active.
- bus_we, output, 1, write enable.
- bus_addr, output, 32, address.
- bus_wdata, output, 32, write data.
- bus_wstrb, output, 4, byte enables (4'b0000 on reads).
- bus_ack, input, 1, one-cycle completion; bus_rdata valid with it.
- bus_rdata, input, 32, read data.
- bus_err, output, 1, sticky watchdog timeout flag.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; run counter, watchdog counter and bus_err cleared. Reset mid-transaction drops bus_req immediately; no ok pulse.
- States: IDLE, DATA, INST, DRAIN.
- bus_req is 1 exactly when state≠IDLE. bus_we/addr/wdata/wstrb come from registers latched at grant and stay constant until the cycle after ack.
- IDLE arbitration at the clock edge; a requester whose ok is high this cycle is ignored:
  - data_req=1 and run<MAX_DATA_RUN (or inst not eligible) → latch data fields, go to DATA; run increments if inst_req is waiting.
  - Otherwise, inst_req=1 and inst_cancel=0 → latch inst_addr, we=0, wstrb=0; go to INST; run clears to 0.
  - run also clears when inst_req=0.
- DATA, bus_ack=1 → next cycle data_ok=1, data_rdata=bus_rdata (stores: don't-care); state → IDLE.
- INST, bus_ack=1:
  - inst_cancel=0 → next cycle inst_ok=1, inst_rdata=bus_rdata; state → IDLE.
  - inst_cancel=1 in the same cycle → discard; IDLE; no inst_ok.
- INST, inst_cancel=1 without ack → DRAIN. DRAIN, bus_ack → IDLE; no inst_ok.
- Latency: req sampled at edge N → bus_req high cycle N+1; ack in cycle K → ok in cycle K+1. Minimum 2 cycles req→ok.
- Watchdog: counter resets on entering a non-IDLE state and counts each non-IDLE cycle. On reaching TIMEOUT without ack:
  - bus_err←1 (sticky until reset); state → IDLE.
  - Owner's ok pulses next cycle with rdata=0 (DRAIN: no pulse).
- stall = (data_req & ~data_ok) | (inst_req & ~inst_cancel & ~inst_ok). Combinational.
- Ack arriving in IDLE is ignored.

Test Plan:
- Load only: data_req, addr 0x100, we=0; bus acks 1 cycle after bus_req with 0xCAFEF00D → data_ok in cycle 3 with data_rdata 0xCAFEF00D; stall high cycles 0–2; bus_wstrb=0.
- Simultaneous inst_req and data store (addr 0x40, wdata 0x11223344, wstrb 4'b0011) → data served first with bus_we=1 and exact latched fields; inst granted the cycle after data_ok; inst_ok carries the bus word.
- Starvation: data_req re-asserted every cycle after each ok with inst_req held, MAX_DATA_RUN=4 → exactly 4 data grants, then inst granted.
- Flush: inst in flight, inst_cancel pulsed 2 cycles before ack → DRAIN; no inst_ok; next IDLE grant is the new inst_addr. Repeat with cancel coincident with ack → no inst_ok.
- Watchdog: TIMEOUT=8, bus never acks a load → after 8 bus_req cycles bus_err=1, data_ok pulses with rdata 0, state IDLE; later normal access still works and bus_err stays 1.
- Async reset asserted mid-DATA → all outputs 0 immediately (before next clock edge); no ok after release; a fresh request completes normally.
